// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the mul_share_arbiter block:
// FSM state encoding, owner/grant encoding, default sizes, stats width.
package mul_arb_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_REC_W   = 4;
    localparam int DEF_MUL_LAT = 2;
    localparam int STAT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;

    // Latency counter width; at least one bit even for a combinational multiplier.
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus of mul_share_arbiter: two request channels, two
// response valid/ready pairs and the shared product bus.
interface mul_share_arbiter_if #(
    parameter int WIDTH = mul_arb_pkg::DEF_WIDTH,
    parameter int REC_W = mul_arb_pkg::DEF_REC_W
);
    logic               req0_valid;
    logic               req1_valid;
    logic               req0_ready;
    logic               req1_ready;
    logic [WIDTH-1:0]   req0_x;
    logic [WIDTH-1:0]   req1_x;
    logic [WIDTH-1:0]   req0_y;
    logic [WIDTH-1:0]   req1_y;
    logic               req0_signed;
    logic               req1_signed;
    logic [REC_W-1:0]   req0_rec;
    logic [REC_W-1:0]   req1_rec;
    logic               rsp0_valid;
    logic               rsp1_valid;
    logic               rsp0_ready;
    logic               rsp1_ready;
    logic [2*WIDTH-1:0] rsp_p;

    // Operand sources / product consumers.
    modport master (
        output req0_valid, req1_valid, req0_x, req1_x, req0_y, req1_y,
               req0_signed, req1_signed, req0_rec, req1_rec, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_p
    );

    // The arbiter.
    modport slave (
        input  req0_valid, req1_valid, req0_x, req1_x, req0_y, req1_y,
               req0_signed, req1_signed, req0_rec, req1_rec, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_p
    );
endinterface

// File: rtl/mul_share_arbiter_rr_arb2.sv
// Two-input round-robin grant logic. Purely combinational; the
// last-grant pointer lives in the parent.
module rr_arb2
    import mul_arb_pkg::*;
(
    input  logic [1:0] valids,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    // Single requester wins outright; on contention the one not granted last wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        grant_valid = valids[0] | valids[1];
        grant_id    = OWNER0;
        if (valids[0] && valids[1]) begin
            grant_id = ~last;
        end else if (valids[1]) begin
            grant_id = OWNER1;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one fixed-latency multiplier between two
// requesters with round-robin arbitration, one operation in flight.
// Optional macro MUL_ARB_STATS_EN adds saturating per-requester
// acceptance counters (stat0_cnt, stat1_cnt).
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REC_W   = DEF_REC_W,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                Clk,
    input  logic                Rst,
    mul_share_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]    mul_x,
    output logic [WIDTH-1:0]    mul_y,
    output logic                mul_signed,
    output logic [REC_W-1:0]    mul_rec,
    input  logic [2*WIDTH-1:0]  mul_p,
    output logic                busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat0_cnt,
    output logic [STAT_W-1:0]   stat1_cnt
`endif
);

    localparam int CNT_W = cnt_width(MUL_LAT);

    state_t             state;
    logic               owner;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] result;
    logic               rsp0_valid;
    logic               rsp1_valid;

    logic               grant_valid;
    logic               grant_id;
    logic               accept;
    logic               owner_ready;

    rr_arb2 u_arb (
        .valids      ({bus.req1_valid, bus.req0_valid}),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Ready is only ever offered from IDLE, to the granted requester.
    assign accept         = (state == IDLE) && grant_valid;
    assign bus.req0_ready = accept && (grant_id == OWNER0);
    assign bus.req1_ready = accept && (grant_id == OWNER1);

    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp_p      = result;
    assign busy           = (state != IDLE);

    assign owner_ready = (owner == OWNER1) ? bus.rsp1_ready : bus.rsp0_ready;

    // Operation FSM: latch the granted request, wait out the multiplier
    // latency, capture the product, hold it until the owner takes it.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Rst) begin
            state      <= IDLE;
            owner      <= OWNER0;
            last       <= OWNER1;
            cnt        <= '0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_signed <= 1'b0;
            mul_rec    <= '0;
            result     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (grant_id == OWNER1) begin
                            mul_x      <= bus.req1_x;
                            mul_y      <= bus.req1_y;
                            mul_signed <= bus.req1_signed;
                            mul_rec    <= bus.req1_rec;
                        end else begin
                            mul_x      <= bus.req0_x;
                            mul_y      <= bus.req0_y;
                            mul_signed <= bus.req0_signed;
                            mul_rec    <= bus.req0_rec;
                        end
                        owner <= grant_id;
                        last  <= grant_id;
                        cnt   <= CNT_W'(MUL_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        result     <= mul_p;
                        rsp0_valid <= (owner == OWNER0);
                        rsp1_valid <= (owner == OWNER1);
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        mul_x      <= '0;
                        mul_y      <= '0;
                        mul_signed <= 1'b0;
                        mul_rec    <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_ARB_STATS_EN
    // Count acceptances per requester, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stat0_cnt <= '0;
            stat1_cnt <= '0;
        end else if (accept) begin
            if (grant_id == OWNER0 && stat0_cnt != '1) stat0_cnt <= stat0_cnt + 1'b1;
            if (grant_id == OWNER1 && stat1_cnt != '1) stat1_cnt <= stat1_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one approximate multiplier instance (x, y -> p, fixed pipeline latency) between two requesters.
- Round-robin arbitration; valid/ready handshake on both the request and response sides.
- Forwards each request's signed/unsigned select and error-recovery configuration to the multiplier for that operation.
- Sits between the accelerator's operand sources and the multiplier core; exactly one operation in flight at a time.

Parameters:
- WIDTH, 16, operand width; product width is 2*WIDTH.
- REC_W, 4, width of the error-recovery configuration field.
- MUL_LAT, 2, number of Clk edges from operands applied to mul_p valid; 0 means a combinational multiplier.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present; must stay high with stable payload until accepted.
- req0_ready / req1_ready  out  1  request accepted on a cycle where valid and ready are both high.
- req0_x / req1_x  in  WIDTH  multiplicand.
- req0_y / req1_y  in  WIDTH  multiplier.
- req0_signed / req1_signed  in  1  1 = two's-complement operation.
- req0_rec / req1_rec  in  REC_W  error-recovery configuration.
- rsp0_valid / rsp1_valid  out  1  product available.
- rsp0_ready / rsp1_ready  in  1  consumer accepts the product.
- rsp_p  out  2*WIDTH  product; shared bus, qualified by rspN_valid.
- mul_x, mul_y  out  WIDTH  operands to the multiplier.
- mul_signed  out  1  signedness select to the multiplier.
- mul_rec  out  REC_W  recovery configuration to the multiplier.
- mul_p  in  2*WIDTH  multiplier result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, WAIT, RESP. Registers: operand/config regs, owner bit, last-grant pointer, latency counter, result reg.
- Reset values: state IDLE, all ready/valid outputs 0, mul_x/mul_y/mul_rec/mul_signed 0, rsp_p 0, pointer "last = 1" (req0 wins first), counter 0.
- IDLE, grant computation (combinational):
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester that was not granted last wins.
  - reqN_ready = (state == IDLE) && grant == N. Ready is never high in WAIT or RESP.
- Acceptance edge E0:
  - Latch x, y, signed and rec into the operand regs; set owner = N and pointer = N; counter = MUL_LAT; go to WAIT.
- WAIT:
  - mul_* outputs are driven from the operand regs, stable for the whole operation; mul_* outputs are 0 in IDLE.
  - Counter decrements each edge. At the edge where counter == 0 (edge E0+MUL_LAT+1), capture mul_p into rsp_p and go to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other rspN_valid stays 0.
  - rsp_p is held until rsp<owner>_ready is seen high at an edge, then state goes to IDLE.
  - One bubble cycle follows: the earliest next acceptance is one cycle after the response handshake.
- Latency: rspN_valid first goes high in the cycle after edge E0+MUL_LAT+1.
- Arithmetic: the block does not modify the product; rsp_p = mul_p exactly as captured.
- Boundary conditions:
  - A request that deasserts valid before acceptance is a protocol violation; no latching occurs and the request is simply not granted.
  - A new request arriving during WAIT or RESP waits; its ready stays low.
  - Rst at any state, including mid-WAIT or RESP: all outputs return to reset values at that edge; the in-flight result is discarded and never presented.

Optional Feature:
- Macro: MUL_ARB_STATS_EN.
- Defined:
  - Adds outputs stat0_cnt and stat1_cnt, 16 bits each.
  - Each counter increments on its requester's acceptance and saturates at 16'hFFFF.
  - Both counters clear on Rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mul_arb_pkg holds:
  - the state encoding enum (IDLE/WAIT/RESP);
  - the owner/grant encoding constants;
  - the default WIDTH/REC_W/MUL_LAT constants;
  - the stats counter width.
- Sub-module rr_arb2: two-input round-robin grant logic.
  - Inputs: valids, last pointer.
  - Outputs: grant_valid, grant_id.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
All scenarios use WIDTH=16, MUL_LAT=2 and a registered two-stage exact-product stub as the multiplier.
- Single request: after reset, req0 x=25, y=100, signed=0, rec=4'hF. Required: accepted immediately; mul_rec=4'hF during WAIT; rsp0_valid rises 3 cycles after the acceptance edge with rsp_p=2500; rsp1_valid stays 0.
- Simultaneous requests: req0 (3,5) and req1 (7,9) both valid right after reset. Required: req0 is served first with rsp_p=15, then req1 with rsp_p=63; one idle bubble between the two operations.
- Fairness: both requests held valid continuously for 4 operations. Required: grant order is 0,1,0,1.
- Backpressure: rsp0_ready held low for 5 cycles. Required: rsp0_valid and rsp_p remain stable, req1_ready stays 0 and busy=1; the state returns to IDLE on the edge where ready is seen.
- Signed operation: req1 signed=1, x=16'hFFE7 (-25), y=16'hFF9C (-100). Required: mul_signed=1 throughout the operation; rsp_p=32'd2500.
- Reset mid-operation: Rst pulsed for one cycle during WAIT. Required: next cycle busy=0, all valid/ready outputs 0 and rsp_p=0; the stale product is never delivered; the following request to arrive is granted to req0.
